// File: rtl/cmp_share_arbiter_if.sv
// Bus between the requesting control blocks and the shared comparator arbiter.
// The slave modport is the arbiter side. The master modport is the requester side.
interface cmp_share_arbiter_if #(
  parameter int N       = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] a_flat;
  logic [NUM_REQ*N-1:0] b_flat;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic                 smaller;
  logic                 equal;
  logic                 greater;

  modport slave (
    input  req, a_flat, b_flat,
    output gnt, busy, done, done_id, smaller, equal, greater
  );

  modport master (
    output req, a_flat, b_flat,
    input  gnt, busy, done, done_id, smaller, equal, greater
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// One unsigned N-bit magnitude comparator, time-shared among NUM_REQ requesters.
// Arbitration is round-robin. Each result is registered and tagged with the requester ID.
module comparator_nbit #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         smaller,
  output logic         equal,
  output logic         greater
);
  assign smaller = (a <  b);
  assign equal   = (a == b);
  assign greater = (a >  b);
endmodule

module cmp_share_arbiter #(
  parameter int N       = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  cmp_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [N-1:0]       r_op_a;
  logic [N-1:0]       r_op_b;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_busy;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic               r_smaller;
  logic               r_equal;
  logic               r_greater;

  logic [N-1:0]       w_a_arr [NUM_REQ];
  logic [N-1:0]       w_b_arr [NUM_REQ];
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_ptr_next;
  logic               w_take;
  logic               w_smaller;
  logic               w_equal;
  logic               w_greater;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = bus.a_flat[gi*N +: N];
      assign w_b_arr[gi] = bus.b_flat[gi*N +: N];
    end
  endgenerate

  // Walk from the farthest offset back to the pointer, so the first requester in search order wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[idx]) begin
        w_win_valid = 1'b1;
        w_win_id    = ID_W'(idx);
      end
    end
  end

  assign w_ptr_next = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
  assign w_take     = w_win_valid && (r_state == S_IDLE || r_state == S_RESP);

  comparator_nbit #(.N(N)) u_cmp (
    .a       (r_op_a),
    .b       (r_op_b),
    .smaller (w_smaller),
    .equal   (w_equal),
    .greater (w_greater)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_smaller <= 1'b0;
      r_equal   <= 1'b0;
      r_greater <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      if (w_take) begin
        r_op_a  <= w_a_arr[w_win_id];
        r_op_b  <= w_b_arr[w_win_id];
        r_id    <= w_win_id;
        r_gnt   <= NUM_REQ'(1) << w_win_id;
        r_ptr   <= w_ptr_next;
        r_busy  <= 1'b1;
        r_state <= S_CMP;
      end else begin
        case (r_state)
          S_CMP: begin
            r_smaller <= w_smaller;
            r_equal   <= w_equal;
            r_greater <= w_greater;
            r_done_id <= r_id;
            r_done    <= 1'b1;
            r_state   <= S_RESP;
          end
          S_RESP: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_IDLE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.smaller = r_smaller;
  assign bus.equal   = r_equal;
  assign bus.greater = r_greater;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: it covers grants, round-robin order, captured operands, boundary values and mid-operation reset.
module tb_cmp_share_arbiter;
  localparam int N       = 10;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  cmp_share_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus_if ();

  cmp_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int id, input int a, input int b);
    bus_if.a_flat[id*N +: N] = N'(a);
    bus_if.b_flat[id*N +: N] = N'(b);
  endtask

  // Waits for a grant with a fixed cycle budget. It checks the one-hot value and withdraws that request.
  task automatic wait_gnt(input int exp_id, output int cycles);
    logic [NUM_REQ-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[exp_id] = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus_if.gnt == '0 && cycles < 10);
    chk("gnt_onehot", 32'(bus_if.gnt), 32'(exp_oh));
    chk("busy_in_cmp", 32'(bus_if.busy), 1);
    bus_if.req[exp_id] = 1'b0;
  endtask

  task automatic check_result(input int exp_id, input logic s, input logic e, input logic g);
    @(negedge clk);
    chk("done", 32'(bus_if.done), 1);
    chk("done_id", 32'(bus_if.done_id), 32'(exp_id));
    chk("smaller", 32'(bus_if.smaller), 32'(s));
    chk("equal", 32'(bus_if.equal), 32'(e));
    chk("greater", 32'(bus_if.greater), 32'(g));
    chk("gnt_cleared", 32'(bus_if.gnt), 0);
    $display("[TB] txn id=%0d done=%0d s/e/g=%0d%0d%0d", bus_if.done_id, bus_if.done,
             bus_if.smaller, bus_if.equal, bus_if.greater);
  endtask

  task automatic serve(input int exp_id, input logic s, input logic e, input logic g, output int cycles);
    wait_gnt(exp_id, cycles);
    check_result(exp_id, s, e, g);
  endtask

  task automatic single(input int id, input int a, input int b, input logic s, input logic e, input logic g);
    int cyc;
    set_ops(id, a, b);
    bus_if.req[id] = 1'b1;
    serve(id, s, e, g, cyc);
    @(negedge clk);
    chk("done_pulse_end", 32'(bus_if.done), 0);
    chk("result_hold", 32'({bus_if.smaller, bus_if.equal, bus_if.greater}), 32'({s, e, g}));
  endtask

  initial begin
    int cyc;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus_if.req    = '0;
    bus_if.a_flat = '0;
    bus_if.b_flat = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus_if.gnt), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_done", 32'(bus_if.done), 0);
    chk("rst_done_id", 32'(bus_if.done_id), 0);
    chk("rst_results", 32'({bus_if.smaller, bus_if.equal, bus_if.greater}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_gnt", 32'(bus_if.gnt), 0);

    // Single request from requester 1.
    single(1, 5, 99, 1'b1, 1'b0, 1'b0);
    chk("idle_busy", 32'(bus_if.busy), 0);

    // Continuous load from all four requesters. Requester 1 was last served, so the pointer is at 2.
    // Serve requesters 2 and 3 first so that the pointer returns to 0.
    single(2, 7, 7, 1'b0, 1'b1, 1'b0);
    single(3, 8, 9, 1'b1, 1'b0, 1'b0);
    set_ops(0, 0, 0);
    set_ops(1, 66, 66);
    set_ops(2, 100, 47);
    set_ops(3, 1023, 0);
    bus_if.req = 4'b1111;
    serve(0, 1'b0, 1'b1, 1'b0, cyc);
    serve(1, 1'b0, 1'b1, 1'b0, cyc);
    chk("b2b_gap_1", 32'(cyc), 1);
    serve(2, 1'b0, 1'b0, 1'b1, cyc);
    chk("b2b_gap_2", 32'(cyc), 1);
    serve(3, 1'b0, 1'b0, 1'b1, cyc);
    chk("b2b_gap_3", 32'(cyc), 1);
    @(negedge clk);

    // Round-robin order: after requester 2 is served, the pointer is at 3, so the order is 0 then 2.
    single(2, 1, 2, 1'b1, 1'b0, 1'b0);
    set_ops(0, 4, 4);
    set_ops(2, 9, 3);
    bus_if.req = 4'b0101;
    serve(0, 1'b0, 1'b1, 1'b0, cyc);
    serve(2, 1'b0, 1'b0, 1'b1, cyc);
    @(negedge clk);
    // After requester 0 is served, the pointer is at 1, so the order is 2 then 0.
    single(0, 3, 1, 1'b0, 1'b0, 1'b1);
    set_ops(0, 11, 12);
    set_ops(2, 12, 12);
    bus_if.req = 4'b0101;
    serve(2, 1'b0, 1'b1, 1'b0, cyc);
    serve(0, 1'b1, 1'b0, 1'b0, cyc);
    @(negedge clk);

    // An operand change after the grant must not affect the result.
    set_ops(3, 10, 20);
    bus_if.req[3] = 1'b1;
    wait_gnt(3, cyc);
    set_ops(3, 30, 20);
    check_result(3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Boundary values.
    single(1, 1023, 1022, 1'b0, 1'b0, 1'b1);
    single(1, 0, 1023, 1'b1, 1'b0, 1'b0);
    single(1, 1023, 1023, 1'b0, 1'b1, 1'b0);

    // Reset during the compare cycle.
    set_ops(2, 1, 0);
    bus_if.req[2] = 1'b1;
    wait_gnt(2, cyc);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus_if.gnt), 0);
    chk("arst_busy", 32'(bus_if.busy), 0);
    chk("arst_results", 32'({bus_if.smaller, bus_if.equal, bus_if.greater}), 0);
    @(negedge clk);
    chk("arst_no_done", 32'(bus_if.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", 32'(bus_if.done), 0);
    single(3, 3, 3, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
